// File: rtl/slave.sv
// AXI-Stream receiver: arms on en, accepts trans_lenth beats, pulses done.
// Optional running checksum when SLAVE_CHECKSUM_EN is defined.
module slave #(
  parameter int data_width  = 32,
  parameter int trans_width = 4,
  parameter int trans_lenth = 2**trans_width
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [data_width-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  en,
  output logic                  busy,
  output logic                  done,
  output logic [trans_width:0]  rx_count,
  output logic [data_width-1:0] last_data,
  output logic [data_width-1:0] checksum
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RECV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [trans_width:0] LEN =
    (trans_width+1)'(trans_lenth);

  logic [1:0]            state_q, state_d;
  logic                  s_ready_q, s_ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [trans_width:0]  rx_count_q, rx_count_d;
  logic [data_width-1:0] last_data_q, last_data_d;

  always_comb begin
    state_d     = state_q;
    rx_count_d  = rx_count_q;
    last_data_d = last_data_q;
    unique case (state_q)
      IDLE: begin
        if (en) begin
          state_d    = RECV;
          rx_count_d = '0;
        end
      end
      RECV: begin
        if (s_valid) begin
          rx_count_d  = rx_count_q + 1'b1;
          last_data_d = s_data;
          if (rx_count_q + 1'b1 == LEN)
            state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Handshake outputs are registered off the next state
    s_ready_d = (state_d == RECV);
    busy_d    = (state_d == RECV);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      s_ready_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rx_count_q  <= '0;
      last_data_q <= '0;
    end else begin
      state_q     <= state_d;
      s_ready_q   <= s_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rx_count_q  <= rx_count_d;
      last_data_q <= last_data_d;
    end
  end

`ifdef SLAVE_CHECKSUM_EN
  logic [data_width-1:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (state_q == IDLE && en)
      checksum_d = '0;
    else if (state_q == RECV && s_valid)
      checksum_d = checksum_q + s_data;
  end

  always_ff @(posedge clk) begin
    if (rst) checksum_q <= '0;
    else     checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

  assign s_ready   = s_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign rx_count  = rx_count_q;
  assign last_data = last_data_q;

endmodule

// File: tb/tb_slave.sv
// Self-checking bench for slave against a transfer-level reference model.
// Honours SLAVE_CHECKSUM_EN for the expected checksum.
module tb_slave;

  localparam int DW  = 32;
  localparam int TW  = 4;
  localparam int LEN = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic          en;
  logic          busy;
  logic          done;
  logic [TW:0]   rx_count;
  logic [DW-1:0] last_data;
  logic [DW-1:0] checksum;

  int passed = 0;
  int total  = 0;

  // Reference model: transfer in progress, done pulse, beats, last, sum
  bit          m_busy;
  bit          m_done;
  int          m_cnt;
  logic [DW-1:0] m_last;
  logic [DW-1:0] m_sum;

  slave #(.data_width(DW), .trans_width(TW), .trans_lenth(LEN)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .en(en), .busy(busy), .done(done),
    .rx_count(rx_count), .last_data(last_data), .checksum(checksum)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] sum_of(input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
`ifdef SLAVE_CHECKSUM_EN
    return a + b;
`else
    return a - a + b - b;
`endif
  endfunction

  task automatic tick(input bit r, input bit e, input bit v,
                      input logic [DW-1:0] d);
    rst = r; en = e; s_valid = v; s_data = d;
    @(posedge clk);
    if (r) begin
      m_busy = 0; m_done = 0; m_cnt = 0; m_last = '0; m_sum = '0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_busy) begin
      if (v) begin
        m_cnt++;
        m_last = d;
        m_sum  = sum_of(m_sum, d);
        if (m_cnt == LEN) begin
          m_busy = 0;
          m_done = 1;
        end
      end
    end else if (e) begin
      m_busy = 1; m_cnt = 0; m_sum = '0;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) tick(1, 0, 0, '0);
    tick(0, 0, 0, '0);
    total++;
    if ({s_ready, busy, done, rx_count, last_data, checksum} !== '0)
      $display("FAIL reset_outputs got rdy=%b busy=%b done=%b cnt=%0d last=%h sum=%h want all 0",
               s_ready, busy, done, rx_count, last_data, checksum);
    else passed++;
  endtask

  task automatic run_transfer(input string name, input bit gaps);
    int done_cnt = 0;
    int beat = 0;
    int cyc = 0;
    logic [DW-1:0] want_sum;
    want_sum = sum_of('0, 120);
    for (int i = 0; i < 5; i++) tick(0, 1, 0, '0);
    total++;
    if (busy !== 1'b1 || s_ready !== 1'b1 || rx_count !== 0)
      $display("FAIL %s_armed got busy=%b rdy=%b cnt=%0d want 1 1 0",
               name, busy, s_ready, rx_count);
    else passed++;
    while (beat < LEN && cyc < 200) begin
      if (gaps && cyc[0]) tick(0, 0, 0, 32'hDEAD0000 | cyc);
      else begin
        tick(0, 0, 1, beat);
        beat++;
      end
      cyc++;
      if (done) done_cnt++;
      if (beat < LEN && (busy !== 1'b1 || s_ready !== 1'b1)) begin
        total++;
        $display("FAIL %s_busy_mid got busy=%b rdy=%b want 1 1",
                 name, busy, s_ready);
      end
    end
    total++;
    if (rx_count !== LEN || last_data !== 15 || checksum !== want_sum
        || done !== 1'b1 || s_ready !== 1'b0)
      $display("FAIL %s_end got cnt=%0d last=%0d sum=%0d done=%b rdy=%b want 16 15 %0d 1 0",
               name, rx_count, last_data, checksum, done, s_ready, want_sum);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 1, 32'h1234);
      if (done) done_cnt++;
    end
    total++;
    if (done_cnt != 1 || s_ready !== 1'b0 || rx_count !== LEN
        || last_data !== 15)
      $display("FAIL %s_after got done_pulses=%0d rdy=%b cnt=%0d last=%0d want 1 0 16 15",
               name, done_cnt, s_ready, rx_count, last_data);
    else passed++;
  endtask

  task automatic test_idle_ignore();
    logic [TW:0]   c0;
    logic [DW-1:0] l0, s0;
    c0 = rx_count; l0 = last_data; s0 = checksum;
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 1, 32'hAAAA5555);
      total++;
      if (s_ready !== 1'b0 || busy !== 1'b0 || rx_count !== m_cnt
          || last_data !== m_last || checksum !== m_sum)
        $display("FAIL idle_ignore got rdy=%b cnt=%0d last=%h sum=%h want 0 %0d %h %h",
                 s_ready, rx_count, last_data, checksum, m_cnt, m_last, m_sum);
      else passed++;
    end
    total++;
    if (rx_count !== c0 || last_data !== l0 || checksum !== s0)
      $display("FAIL idle_hold got cnt=%0d last=%h want %0d %h",
               rx_count, last_data, c0, l0);
    else passed++;
  endtask

  task automatic test_reset_abort();
    tick(0, 1, 0, '0);
    for (int i = 0; i < 8; i++) tick(0, 0, 1, i);
    total++;
    if (rx_count !== 8 || last_data !== 7)
      $display("FAIL abort_pre got cnt=%0d last=%0d want 8 7",
               rx_count, last_data);
    else passed++;
    tick(1, 1, 1, 32'h99);
    total++;
    if ({s_ready, busy, done, rx_count, last_data, checksum} !== '0)
      $display("FAIL abort_reset got rdy=%b busy=%b done=%b cnt=%0d last=%h want all 0",
               s_ready, busy, done, rx_count, last_data);
    else passed++;
    tick(0, 0, 1, 32'h77);
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || rx_count !== 0)
      $display("FAIL abort_after got done=%b busy=%b cnt=%0d want 0 0 0",
               done, busy, rx_count);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int cyc = 0;
    tick(0, 1, 0, '0);
    while (!done && cyc < 100) begin
      tick(0, 1, 1, $urandom);
      cyc++;
    end
    total++;
    if (done !== 1'b1 || rx_count !== LEN)
      $display("FAIL b2b_done got done=%b cnt=%0d want 1 16", done, rx_count);
    else passed++;
    tick(0, 1, 1, '0);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || rx_count !== LEN)
      $display("FAIL b2b_idle got busy=%b done=%b cnt=%0d want 0 0 16",
               busy, done, rx_count);
    else passed++;
    tick(0, 1, 1, '0);
    total++;
    if (busy !== 1'b1 || s_ready !== 1'b1 || rx_count !== 0
        || checksum !== '0)
      $display("FAIL b2b_rearm got busy=%b rdy=%b cnt=%0d sum=%h want 1 1 0 0",
               busy, s_ready, rx_count, checksum);
    else passed++;
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 600; i++) begin
      tick(($urandom_range(0, 79) == 0), $urandom_range(0, 1),
           $urandom_range(0, 2) != 0, $urandom);
      total++;
      if (s_ready !== m_busy || busy !== m_busy || done !== m_done
          || rx_count !== m_cnt || last_data !== m_last
          || checksum !== m_sum) begin
        if (errs < 10)
          $display("FAIL random cyc %0d got rdy=%b busy=%b done=%b cnt=%0d last=%h sum=%h want %b %b %b %0d %h %h",
                   i, s_ready, busy, done, rx_count, last_data, checksum,
                   m_busy, m_busy, m_done, m_cnt, m_last, m_sum);
        errs++;
      end else passed++;
    end
  endtask

  initial begin
    rst = 1; en = 0; s_valid = 0; s_data = '0;
    m_busy = 0; m_done = 0; m_cnt = 0; m_last = '0; m_sum = '0;
    test_reset();
    run_transfer("full", 0);
    run_transfer("gaps", 1);
    test_idle_ignore();
    test_reset_abort();
    run_transfer("post_abort", 0);
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/slave.md
SLAVE -- requirements
Module: slave

Interface
REQ-001 Parameter data_width, default 32: width of s_data and data outputs.
REQ-002 Parameter trans_width, default 4: width of the beat counter.
REQ-003 Parameter trans_lenth, default 2**trans_width: beats per transfer; legal range 1..2**trans_width.
REQ-004 clk  input  1: single clock; all logic on rising edge.
REQ-005 rst  input  1: synchronous, active-high reset.
REQ-006 s_data  input  data_width: AXI-Stream slave data.
REQ-007 s_valid  input  1: AXI-Stream slave valid.
REQ-008 s_ready  output  1: AXI-Stream slave ready, registered.
REQ-009 en  input  1: level start request; arms one transfer.
REQ-010 busy  output  1: high while a transfer is in progress.
REQ-011 done  output  1: one-cycle pulse after the final beat is accepted.
REQ-012 rx_count  output  trans_width+1: beats accepted in the current or last transfer.
REQ-013 last_data  output  data_width: most recently accepted beat.
REQ-014 checksum  output  data_width: running sum of accepted beats for the current or last transfer.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RECV and DONE.
REQ-016 IDLE: s_ready=0, busy=0; en=1 -> RECV on the next edge, clearing rx_count and checksum.
REQ-017 RECV: s_ready=1 and busy=1; en is ignored.
REQ-018 A beat is accepted only on an edge where s_valid=1 and s_ready=1.
- On acceptance: last_data <= s_data, rx_count += 1, checksum += s_data.
- Sum is modulo 2**data_width.
REQ-019 When the accepted beat brings rx_count to trans_lenth, RECV -> DONE and s_ready SHALL deassert on that same edge; no further beat is accepted.
REQ-020 s_valid low in RECV: no state change, no counter change; wait indefinitely.
REQ-021 DONE lasts exactly one cycle: done=1, s_ready=0, busy=0; then -> IDLE.
- If en=1 in that cycle, IDLE re-arms on the following edge.
REQ-022 s_data and s_valid SHALL be ignored outside RECV.
REQ-023 rx_count, last_data and checksum SHALL hold their values from DONE until the next IDLE->RECV transition.
REQ-024 Acceptance latency: outputs update on the same edge that samples the handshake (zero wait states).

Reset
REQ-025 rst=1 at a rising edge SHALL force the IDLE state and clear all outputs: s_ready=0, busy=0, done=0, rx_count=0, last_data=0, checksum=0.
REQ-026 Reset SHALL override en and s_valid; asserting rst during RECV aborts the transfer without a done pulse.
REQ-027 Before the first reset edge, output values are undefined.

Configuration
REQ-028 Macro SLAVE_CHECKSUM_EN defined: the checksum accumulator is implemented per REQ-018.
REQ-029 SLAVE_CHECKSUM_EN undefined: no accumulator logic exists and checksum is driven constant 0; all other behaviour is unchanged.

Verification
REQ-030 rst=1 for 5 cycles, then rst=0 -> all outputs 0, state IDLE.
REQ-031 en=1 for 5 cycles, then s_valid=1 with s_data=0..15, one beat per cycle.
- busy=1 and s_ready=1 during the beats.
- After beat 15: rx_count=16, last_data=15, checksum=120.
- done=1 for exactly one cycle, then s_ready=0.
REQ-032 Same transfer with s_valid toggled low every other cycle -> still exactly 16 beats accepted; checksum=120; gaps add no count.
REQ-033 s_valid=1 with s_data=0xAAAA5555 while IDLE (en=0) -> s_ready=0; rx_count, last_data and checksum unchanged.
REQ-034 Assert rst after beat 7 of a transfer -> next cycle all outputs 0 and no done pulse.
- A subsequent en and 16 beats complete normally.
REQ-035 Build with SLAVE_CHECKSUM_EN undefined, run the REQ-031 stimulus -> checksum=0; all other results identical.
